// File: rtl/wb_bus_monitor.sv
// Purpose: passive Wishbone B4 protocol monitor (classic or pipelined) with sticky violation flags, IRQ and first-fault capture.
// Latency: violations are detected combinationally and appear on o_viol/o_irq/o_first_* one clock after the offending cycle.
// Backpressure: none exerted; the monitor only observes stall/ack/err and never drives the bus.
//
// Ports:
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_wb_cyc/stb/we/addr/data/sel   master request lines (observed)
//   i_wb_stall/ack/err      slave response lines (observed)
//   i_clear                 clears sticky flags and capture registers
//   o_viol                  sticky violation flags, one bit per rule
//   o_irq                   OR of o_viol
//   o_first_code/addr       rule index and address of the first captured violation
//   o_outstanding           current outstanding request count
module wb_bus_monitor #(
    parameter int AW                 = 32,
    parameter int DW                 = 32,
    parameter int LGDEPTH            = 4,
    parameter int ACK_TIMEOUT        = 0,
    parameter int OPT_PIPELINED      = 1,
    parameter int OPT_BUS_ABORT      = 1,
    parameter int OPT_MINCLOCK_DELAY = 0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_wb_cyc,
    input  logic               i_wb_stb,
    input  logic               i_wb_we,
    input  logic [AW-1:0]      i_wb_addr,
    input  logic [DW-1:0]      i_wb_data,
    input  logic [DW/8-1:0]    i_wb_sel,
    input  logic               i_wb_stall,
    input  logic               i_wb_ack,
    input  logic               i_wb_err,
    input  logic               i_clear,
    output logic [7:0]         o_viol,
    output logic               o_irq,
    output logic [2:0]         o_first_code,
    output logic [AW-1:0]      o_first_addr,
    output logic [LGDEPTH-1:0] o_outstanding
);

    localparam int SW   = DW / 8;
    localparam int REQW = 1 + AW + DW + SW;
    localparam int WCW  = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    localparam logic PIPE_EN  = (OPT_PIPELINED != 0);
    localparam logic ABORT_EN = (OPT_BUS_ABORT != 0);
    localparam logic MINCLK   = (OPT_MINCLOCK_DELAY != 0);
    localparam logic TO_EN    = (ACK_TIMEOUT > 0);

    localparam logic [LGDEPTH-1:0] OUT_SAT       = '1;
    // Highest count a legal bus may reach; one more accept is an overflow attempt.
    localparam logic [LGDEPTH-1:0] OUT_LEGAL_MAX = {{(LGDEPTH-1){1'b1}}, 1'b0};
    localparam logic [WCW-1:0]     WCNT_LIMIT    = WCW'(ACK_TIMEOUT);
    localparam logic [WCW-1:0]     WCNT_SAT      = '1;

    // History registers
    logic             prev_stalled;   // previous cycle had cyc & stb & stall
    logic [REQW-1:0]  prev_req;       // previous cycle's {we, addr, data, sel}
    logic             prev_err;       // previous cycle had cyc & err
    logic [WCW-1:0]   wcnt;

    // Combinational observation
    logic                stall_eff;
    logic                accept;
    logic                resp;
    logic                wait_now;
    logic [REQW-1:0]     req_cur;
    logic [LGDEPTH:0]    out_sum;
    logic [LGDEPTH:0]    out_dec;
    logic [LGDEPTH-1:0]  out_nxt;
    logic [WCW-1:0]      wcnt_nxt;
    logic [7:0]          viol_now;
    logic [2:0]          code_now;
    logic [7:0]          viol_kept;
    logic [7:0]          viol_nxt;

    assign stall_eff = PIPE_EN ? i_wb_stall : 1'b0;
    assign accept    = i_wb_cyc & i_wb_stb & ~stall_eff;
    assign resp      = i_wb_ack | i_wb_err;
    assign wait_now  = i_wb_cyc & ~i_wb_stb & (o_outstanding != '0) & ~resp;
    assign req_cur   = {i_wb_we, i_wb_addr, i_wb_data, i_wb_sel};
    assign out_sum   = {1'b0, o_outstanding} + {{LGDEPTH{1'b0}}, accept};

    // Outstanding count: saturating at both ends, cleared whenever the cycle drops.
    always_comb begin
        out_dec = out_sum;
        out_nxt = o_outstanding;
        if (!i_wb_cyc) begin
            out_nxt = '0;
        end else if (resp && (out_sum == '0)) begin
            out_nxt = '0;
        end else begin
            out_dec = resp ? (out_sum - (LGDEPTH+1)'(1)) : out_sum;
            if (out_dec > {1'b0, OUT_SAT})
                out_nxt = OUT_SAT;
            else
                out_nxt = out_dec[LGDEPTH-1:0];
        end
    end

    always_comb begin
        wcnt_nxt = '0;
        if (wait_now)
            wcnt_nxt = (wcnt == WCNT_SAT) ? wcnt : (wcnt + WCW'(1));
    end

    always_comb begin
        viol_now    = '0;
        viol_now[0] = i_wb_stb & ~i_wb_cyc;
        viol_now[1] = i_wb_ack & i_wb_err;
        // A same-cycle response to the request being accepted is fine unless forbidden.
        viol_now[2] = i_wb_cyc & resp & (o_outstanding == '0) & ~(accept & ~MINCLK);
        viol_now[3] = ~i_wb_cyc & resp & (o_outstanding == '0);
        viol_now[4] = i_wb_cyc & (o_outstanding == OUT_LEGAL_MAX) & accept & ~resp;
        viol_now[5] = TO_EN & wait_now & (wcnt >= WCNT_LIMIT);
        // A stalled request must be held; dropping cyc is a legal abort.
        viol_now[6] = PIPE_EN & prev_stalled & i_wb_cyc & (~i_wb_stb | (req_cur != prev_req));
        viol_now[7] = ABORT_EN & prev_err & i_wb_cyc;
    end

    // Lowest set bit wins so simultaneous violations report a stable code.
    always_comb begin
        code_now = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (viol_now[i])
                code_now = 3'(i);
        end
    end

    assign viol_kept = i_clear ? 8'h00 : o_viol;
    assign viol_nxt  = viol_kept | viol_now;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            prev_stalled  <= 1'b0;
            prev_req      <= '0;
            prev_err      <= 1'b0;
            wcnt          <= '0;
            o_outstanding <= '0;
            o_viol        <= 8'h00;
            o_irq         <= 1'b0;
            o_first_code  <= 3'd0;
            o_first_addr  <= '0;
        end else begin
            prev_stalled  <= i_wb_cyc & i_wb_stb & i_wb_stall;
            prev_req      <= req_cur;
            prev_err      <= i_wb_cyc & i_wb_err;
            wcnt          <= wcnt_nxt;
            o_outstanding <= out_nxt;
            o_viol        <= viol_nxt;
            o_irq         <= |viol_nxt;
            if (((o_viol == 8'h00) || i_clear) && (viol_now != 8'h00)) begin
                o_first_code <= code_now;
                o_first_addr <= i_wb_addr;
            end else if (i_clear) begin
                o_first_code <= 3'd0;
                o_first_addr <= '0;
            end
        end
    end

endmodule
